// File: rtl/gor_cell.sv
// Bitwise OR leaf cell with registered result and saturating rise counter.
// Optional counter enabled by defining GOR_RISE_CNT_EN; otherwise rise_cnt is 0.
module gor_cell #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             any_q,
   output logic [CNT_W-1:0] rise_cnt
);

   logic [WIDTH-1:0] w_or;
   logic             w_any;
   logic [WIDTH-1:0] r_yq;
   logic             r_any;

   assign w_or  = a | b;
   assign w_any = |w_or;
   assign y     = w_or;
   assign y_q   = r_yq;
   assign any_q = r_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_yq  <= '0;
         r_any <= 1'b0;
      end else begin
         r_yq  <= w_or;
         r_any <= w_any;
      end
   end

`ifdef GOR_RISE_CNT_EN
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;
   logic             w_sat;

   // Rise is judged against the registered flag, so it lands on the edge that sets any_q
   assign w_rise   = w_any & ~r_any;
   assign w_sat    = &r_cnt;
   assign rise_cnt = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_rise && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign rise_cnt = '0;
`endif

endmodule

// File: tb/tb_gor_cell.sv
// Randomized self-checking bench for gor_cell against a behavioural model.
// Two instances: a 4-bit/8-bit-counter one and a 1-bit/2-bit-counter one.
module tb_gor_cell;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [0:0] a1 = '0, b1 = '0;
   logic [3:0] y4, yq4;
   logic [0:0] y1, yq1;
   logic       any4, any1;
   logic [7:0] cnt4;
   logic [1:0] cnt1;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 0;

`ifdef GOR_RISE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   gor_cell #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
      .y(y4), .y_q(yq4), .any_q(any4), .rise_cnt(cnt4)
   );

   gor_cell #(.WIDTH(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
      .y(y1), .y_q(yq1), .any_q(any1), .rise_cnt(cnt1)
   );

   // Reference model: what the outputs must be after the latest sampling edge
   int m_yq4, m_any4, m_cnt4;
   int m_yq1, m_any1, m_cnt1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_yq4 <= 0; m_any4 <= 0; m_cnt4 <= 0;
         m_yq1 <= 0; m_any1 <= 0; m_cnt1 <= 0;
      end else begin
         m_yq4  <= int'(a4 | b4);
         m_any4 <= ((a4 | b4) != 0) ? 1 : 0;
         if (CNT_EN && (a4 | b4) != 0 && m_any4 == 0 && m_cnt4 < 255)
            m_cnt4 <= m_cnt4 + 1;
         m_yq1  <= int'(a1 | b1);
         m_any1 <= ((a1 | b1) != 0) ? 1 : 0;
         if (CNT_EN && (a1 | b1) != 0 && m_any1 == 0 && m_cnt1 < 3)
            m_cnt1 <= m_cnt1 + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("y4", 32'(y4), 32'(a4) | 32'(b4));
         chk("y1", 32'(y1), 32'(a1) | 32'(b1));
         chk("yq4", 32'(yq4), 32'(m_yq4));
         chk("any4", 32'(any4), 32'(m_any4));
         chk("cnt4", 32'(cnt4), 32'(m_cnt4));
         chk("yq1", 32'(yq1), 32'(m_yq1));
         chk("any1", 32'(any1), 32'(m_any1));
         chk("cnt1", 32'(cnt1), 32'(m_cnt1));
      end
   end

   task automatic drv(input logic [3:0] va, input logic [3:0] vb,
                      input logic va1, input logic vb1);
      @(posedge clk);
      #3;
      a4 = va; b4 = vb; a1 = va1; b1 = vb1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] tt;
      logic [3:0] exp_tt;
      logic [2:0] exp_sat [5];
      exp_tt = 4'b1110;
      exp_sat[0] = 3'd1; exp_sat[1] = 3'd2; exp_sat[2] = 3'd3;
      exp_sat[3] = 3'd3; exp_sat[4] = 3'd3;

      // Truth table on combinational path, valid even in reset
      for (int i = 0; i < 4; i++) begin
         tt = 2'(i);
         a1 = tt[1]; b1 = tt[0];
         #10;
         chk("tt_y", 32'(y1), 32'(exp_tt[i]));
      end
      a1 = 0; b1 = 0;
      #2;
      chk("rst_yq4", 32'(yq4), 32'd0);
      chk("rst_cnt4", 32'(cnt4), 32'd0);
      chk("rst_any1", 32'(any1), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      chk_on = 1;

      // Registered path: 01 applied before edge n
      drv(4'h0, 4'h0, 1'b0, 1'b1);
      #2;
      chk("reg_pre_yq", 32'(yq1), 32'd0);
      chk("reg_pre_any", 32'(any1), 32'd0);
      after_edge();
      chk("reg_post_yq", 32'(yq1), 32'd1);
      chk("reg_post_any", 32'(any1), 32'd1);

      // Edge counting from a fresh reset
      drv(4'h0, 4'h0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      drv(4'h0, 4'h0, 1'b1, 1'b1);
      drv(4'h0, 4'h0, 1'b1, 1'b1);
      drv(4'h0, 4'h0, 1'b0, 1'b0);
      drv(4'h0, 4'h0, 1'b1, 1'b0);
      after_edge();
      chk("edge_cnt", 32'(cnt1), CNT_EN ? 32'd2 : 32'd0);
      chk("edge_yq", 32'(yq1), 32'd1);

      // Saturation of the 2-bit counter
      drv(4'h0, 4'h0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drv(4'h0, 4'h0, 1'b1, 1'b0);
         after_edge();
         chk("sat_cnt", 32'(cnt1), CNT_EN ? 32'(exp_sat[k]) : 32'd0);
         if (k < 4) drv(4'h0, 4'h0, 1'b0, 1'b0);
      end

      // Async reset between edges with y_q=1 and count saturated
      #1;
      a4 = 4'h5;
      rst_n = 1'b0;
      #1;
      chk("ar_yq", 32'(yq1), 32'd0);
      chk("ar_any", 32'(any1), 32'd0);
      chk("ar_cnt", 32'(cnt1), 32'd0);
      chk("ar_y", 32'(y1), 32'd1);
      chk("ar_y4", 32'(y4), 32'h5);
      drv(4'h0, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Randomized run, sparse activity so rises and holds both occur
      for (int k = 0; k < 600; k++) begin
         logic [3:0] ra, rb;
         logic ra1, rb1;
         ra  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         rb  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         ra1 = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0;
         rb1 = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         drv(ra, rb, ra1, rb1);
         if ($urandom_range(0, 99) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      after_edge();
      chk_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
